// File: rtl/b2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the controller state encoding, the default operand sizing and the sizing helpers.
`timescale 1ns/1ps
package b2bcd_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/b2bcd_seq_ctrl_if.sv
// Operand/result handshake bundle of the converter.
// The slave side is the converter; the master side is the producer/consumer pair.
`timescale 1ns/1ps
interface b2bcd_seq_ctrl_if
  import b2bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      b;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   a;
  logic                  busy;

  modport slave (
    input  in_valid,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output a,
    output busy
  );

  modport master (
    output in_valid,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  a,
    input  busy
  );

endinterface

// File: rtl/bcd_dabble_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decade.
`timescale 1ns/1ps
module bcd_dabble_digit (
  input  logic [3:0] raw,
  output logic [3:0] fixed
);

  assign fixed = (raw >= 4'd5) ? (raw + 4'd3) : raw;

endmodule

// File: rtl/b2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock,
// with a valid/ready operand input and a valid/ready result output.
`timescale 1ns/1ps
module b2bcd_seq_ctrl
  import b2bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  b2bcd_seq_ctrl_if.slave       bus
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam int                BCD_W    = 4 * DIGITS;
  localparam int                CAT_W    = BCD_W + WIDTH;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  generate
    if (pow10(DIGITS) <= (64'd1 << WIDTH)) begin : g_range_check
      $error("b2bcd_seq_ctrl: DIGITS too small to hold every WIDTH-bit value");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    bin_reg,   bin_next;
  logic [BCD_W-1:0]    bcd_reg,   bcd_next;
  logic [CNT_W-1:0]    cnt_reg,   cnt_next;

  logic [BCD_W-1:0]    bcd_fixed;
  logic [CAT_W-1:0]    cat_shifted;
  logic                accept;
  logic                handshake;
  logic                last_shift;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_dabble_digit u_digit (
        .raw   (bcd_reg[4*gi +: 4]),
        .fixed (bcd_fixed[4*gi +: 4])
      );
    end
  endgenerate

  // Corrected digits and the binary operand shift as one register; the binary MSB lands in BCD bit 0.
  assign cat_shifted = {bcd_fixed, bin_reg} << 1;

  assign accept     = (state_reg == IDLE)  && bus.in_valid;
  assign handshake  = (state_reg == DONE)  && bus.out_ready;
  assign last_shift = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)     state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    if (handshake)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    bin_next = bin_reg;
    bcd_next = bcd_reg;
    cnt_next = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          bin_next = bus.b;
          bcd_next = '0;
          cnt_next = '0;
        end
      end
      SHIFT: begin
        bin_next = cat_shifted[WIDTH-1:0];
        bcd_next = cat_shifted[CAT_W-1:WIDTH];
        cnt_next = last_shift ? '0 : (cnt_reg + 1'b1);
      end
      default: begin
      end
    endcase
  end

  // A reset mid-conversion discards the partial result as well as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg <= '0;
      bcd_reg <= '0;
      cnt_reg <= '0;
    end else begin
      bin_reg <= bin_next;
      bcd_reg <= bcd_next;
      cnt_reg <= cnt_next;
    end
  end

  always_comb begin
    bus.in_ready  = (state_reg == IDLE);
    bus.busy      = (state_reg == SHIFT);
    bus.out_valid = (state_reg == DONE);
    bus.a         = bcd_reg;
  end

endmodule

// File: tb/tb_b2bcd_seq_ctrl.sv
// Directed bench for b2bcd_seq_ctrl (WIDTH=8, DIGITS=3): latency, back-to-back,
// backpressure, mid-conversion reset, ignored operands and a full 0..255 sweep.
`timescale 1ns/1ps
module tb_b2bcd_seq_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  b2bcd_seq_ctrl_if #(.WIDTH(8), .DIGITS(3)) bus ();

  b2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] d2, d1, d0;
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d2, d1, d0};
  endfunction

  // Called on the negedge just after the accept edge; counts edges until out_valid.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
    end
    check({tag, " latency"}, n, 8);
  endtask

  task automatic run_one(input logic [7:0] bv, input logic [11:0] exp, input string tag);
    check({tag, " idle in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.b        = bv;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.b        = ~bv;
    check({tag, " busy"}, bus.busy, 1);
    wait_valid(tag);
    check({tag, " a"}, bus.a, exp);
    for (int d = 0; d < 3; d++) begin
      check({tag, " digit<=9"}, (bus.a[4*d +: 4] <= 4'd9), 1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, " in_ready after"}, bus.in_ready, 1);
    check({tag, " out_valid after"}, bus.out_valid, 0);
    check({tag, " a held in idle"}, bus.a, exp);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  vals [3];
    logic [11:0] exps [3];
    int          n;

    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.b         = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset a", bus.a, 12'h000);
    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", bus.busy, 0);

    // Idle with in_valid low ignores b
    bus.b = 8'd77;
    repeat (3) @(negedge clk);
    check("idle hold in_ready", bus.in_ready, 1);
    check("idle hold busy", bus.busy, 0);

    // Max operand
    $display("step: b=255");
    run_one(8'd255, 12'h255, "b255");

    // Back-to-back with in_valid held high
    $display("step: back-to-back 0, 99, 13");
    vals[0] = 8'd0;   vals[1] = 8'd99;   vals[2] = 8'd13;
    exps[0] = 12'h000; exps[1] = 12'h099; exps[2] = 12'h013;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.b         = vals[0];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("b2b busy", bus.busy, 1);
      wait_valid("b2b");
      check("b2b a", bus.a, exps[k]);
      if (k < 2) bus.b = vals[k+1];
      else       bus.in_valid = 1'b0;
      @(negedge clk);
      check("b2b in_ready after handshake", bus.in_ready, 1);
      check("b2b out_valid after handshake", bus.out_valid, 0);
      if (k < 2) @(negedge clk);
    end
    bus.out_ready = 1'b0;

    // Backpressure in DONE
    $display("step: b=128 with backpressure");
    bus.in_valid = 1'b1;
    bus.b        = 8'd128;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid("bp");
    for (int c = 0; c < 5; c++) begin
      check("bp a", bus.a, 12'h128);
      check("bp out_valid", bus.out_valid, 1);
      check("bp in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    check("bp a last", bus.a, 12'h128);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp single handshake out_valid", bus.out_valid, 0);
    check("bp in_ready", bus.in_ready, 1);
    @(negedge clk);
    check("bp no second accept", bus.busy, 0);

    // Reset on the 4th SHIFT cycle
    $display("step: reset mid-shift of b=200");
    bus.in_valid = 1'b1;
    bus.b        = 8'd200;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst mid busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid in_ready", bus.in_ready, 1);
    check("rst mid a", bus.a, 12'h000);
    check("rst mid busy cleared", bus.busy, 0);
    check("rst mid out_valid", bus.out_valid, 0);
    run_one(8'd7, 12'h007, "after rst");

    // Operands offered during SHIFT are ignored
    $display("step: b=42 with toggling in_valid during shift");
    bus.in_valid = 1'b1;
    bus.b        = 8'd42;
    @(negedge clk);
    bus.b = 8'd1;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      check("ign in_ready", bus.in_ready, 0);
      bus.in_valid = ~bus.in_valid;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check("ign latency", n, 8);
    check("ign a", bus.a, 12'h042);
    check("ign in_ready in done", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("ign in_ready after", bus.in_ready, 1);

    // Exhaustive sweep
    $display("step: sweep 0..255");
    for (int v = 0; v < 256; v++) begin
      run_one(8'(v), to_bcd(v), "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
